// File: rtl/dwt_pkg.sv
// ----------------------------------------------------------------------------
// dwt_pkg
//   Shared definitions for the Haar DWT blocks: the level sequencer state
//   encoding, the default sample width and small elaboration-time helpers
//   for sizing counters.
// ----------------------------------------------------------------------------
package dwt_pkg;

   // Sample/coefficient width shared with the pair core.
   localparam int DEFAULT_W = 16;

   // Level sequencer states.
   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ISSUE,
      CAPTURE,
      DONE
   } state_t;

   // Smallest r with 2**r >= value (0 for value <= 1).
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int r = 0; r < 31; r++) begin
         if ((1 << r) < value) begin
            result = r + 1;
         end
      end
      return result;
   endfunction

   // True when value is a positive power of two.
   function automatic bit is_pow2(input int value);
      return (value > 0) && ((value & (value - 1)) == 0);
   endfunction

endpackage

// File: rtl/dwt_haar_level_sched.sv
// ----------------------------------------------------------------------------
// dwt_haar_level_sched
//   Multi-level Haar DWT sequencer. Buffers N samples, then time-shares one
//   external combinational pair core over LEVELS decomposition levels, one
//   pair every two cycles, and presents the Mallat-ordered result
//   [cA_L | cD_L | cD_L-1 | ... | cD_1] on array_out with a one-cycle done.
//   The block does no arithmetic; W-bit values pass through unmodified.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   start      : begin a block (sampled in IDLE only, level-sensitive)
//   in_valid   : sample present on in_data
//   in_data    : input sample (ignored outside LOAD)
//   in_ready   : high only while loading samples
//   core_x0    : registered even operand to the pair core
//   core_x1    : registered odd operand to the pair core
//   core_cA    : pair core approximation result
//   core_cD    : pair core detail result
//   core_valid : high while core results are being captured
//   array_out  : result vector, element e at [e*W +: W]
//   busy       : high whenever not IDLE
//   done       : one-cycle pulse when array_out is complete
// ----------------------------------------------------------------------------
module dwt_haar_level_sched
   import dwt_pkg::*;
#(
   parameter int N      = 8,
   parameter int LEVELS = 3,
   parameter int W      = DEFAULT_W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic           in_valid,
   input  logic [W-1:0]   in_data,
   output logic           in_ready,
   output logic [W-1:0]   core_x0,
   output logic [W-1:0]   core_x1,
   input  logic [W-1:0]   core_cA,
   input  logic [W-1:0]   core_cD,
   output logic           core_valid,
   output logic [N*W-1:0] array_out,
   output logic           busy,
   output logic           done
);

   localparam int AW     = clog2(N);
   localparam int IDXW   = AW + 1;
   localparam int KW     = clog2(N / 2) + 1;
   localparam int LVW    = clog2(LEVELS + 1);
   localparam int APPROX = N >> LEVELS;

   // Reject parameter sets that cannot be decomposed cleanly.
   if (N < 2 || !is_pow2(N)) begin : g_bad_n
      $error("dwt_haar_level_sched: N must be a power of two >= 2");
   end
   if (LEVELS < 1 || LEVELS > clog2(N)) begin : g_bad_levels
      $error("dwt_haar_level_sched: LEVELS must be in 1..log2(N)");
   end

   state_t            state_q;
   state_t            state_d;
   logic [IDXW-1:0]   idx_q;
   logic [IDXW-1:0]   len_q;
   logic [KW-1:0]     k_q;
   logic [LVW-1:0]    level_q;
   logic [W-1:0]      inbuf  [N];
   logic [W-1:0]      detbuf [N];

   logic [IDXW-1:0]   half_len;
   logic [IDXW-1:0]   k_ext;
   logic              last_pair;
   logic              last_level;
   logic              last_sample;
   logic [AW-1:0]     rd_even;
   logic [AW-1:0]     rd_odd;
   logic [AW-1:0]     wr_det;

   // Pair k of the current level reads inbuf[2k], inbuf[2k+1]; its detail
   // lands in the upper half of the current length, which is exactly the
   // slot this level's details occupy in Mallat order.
   assign half_len    = len_q >> 1;
   assign k_ext       = IDXW'(k_q);
   assign last_pair   = (k_ext == half_len - IDXW'(1));
   assign last_level  = (level_q == LVW'(LEVELS));
   assign last_sample = (idx_q == IDXW'(N - 1));
   assign rd_even     = AW'({k_q, 1'b0});
   assign rd_odd      = rd_even | AW'(1);
   assign wr_det      = AW'(half_len + k_ext);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. CAPTURE goes straight back to ISSUE across a level
   // boundary so there is no bubble between levels.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = LOAD;
         LOAD:    if (in_valid && last_sample) state_d = ISSUE;
         ISSUE:   state_d = CAPTURE;
         CAPTURE: state_d = (last_pair && last_level) ? DONE : ISSUE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and counters. Approximations are written back in place:
   // inbuf[k] is only overwritten after pair k has read indices 2k and
   // 2k+1, and every later pair reads above 2k, so no live value is lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q   <= '0;
         len_q   <= '0;
         k_q     <= '0;
         level_q <= '0;
         core_x0 <= '0;
         core_x1 <= '0;
         for (int i = 0; i < N; i++) begin
            inbuf[i]  <= '0;
            detbuf[i] <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  idx_q <= '0;
                  for (int i = 0; i < N; i++) begin
                     detbuf[i] <= '0;
                  end
               end
            end
            LOAD: begin
               if (in_valid) begin
                  inbuf[AW'(idx_q)] <= in_data;
                  idx_q             <= idx_q + IDXW'(1);
                  if (last_sample) begin
                     level_q <= LVW'(1);
                     len_q   <= IDXW'(N);
                     k_q     <= '0;
                  end
               end
            end
            ISSUE: begin
               core_x0 <= inbuf[rd_even];
               core_x1 <= inbuf[rd_odd];
            end
            CAPTURE: begin
               inbuf[AW'(k_q)] <= core_cA;
               detbuf[wr_det]  <= core_cD;
               if (!last_pair) begin
                  k_q <= k_q + KW'(1);
               end else if (!last_level) begin
                  level_q <= level_q + LVW'(1);
                  len_q   <= half_len;
                  k_q     <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready   = (state_q == LOAD);
   assign core_valid = (state_q == CAPTURE);
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);

   // Mallat ordering: the final approximations sit in the low inbuf slots,
   // everything above them comes from the detail buffer.
   for (genvar e = 0; e < N; e++) begin : g_out
      if (e < APPROX) begin : g_approx
         assign array_out[e*W +: W] = inbuf[e];
      end else begin : g_detail
         assign array_out[e*W +: W] = detbuf[e];
      end
   end

endmodule

// File: tb/tb_dwt_haar_level_sched.sv
// ----------------------------------------------------------------------------
// tb_dwt_haar_level_sched
//   Directed bench for the Haar level sequencer. Two instances share the
//   stimulus: one with LEVELS=3 and one with LEVELS=1, each driving a stub
//   pair core computing cA=x0+x1, cD=x0-x1 (mod 2^16).
// ----------------------------------------------------------------------------
module tb_dwt_haar_level_sched;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         in_valid;
   logic [15:0]  in_data;

   logic         in_ready_a, core_valid_a, busy_a, done_a;
   logic [15:0]  core_x0_a, core_x1_a, core_ca_a, core_cd_a;
   logic [127:0] arr_a;

   logic         in_ready_b, core_valid_b, busy_b, done_b;
   logic [15:0]  core_x0_b, core_x1_b, core_ca_b, core_cd_b;
   logic [127:0] arr_b;

   int tests_run = 0;
   int tests_failed = 0;

   logic [15:0] exp_l3 [8] = '{16'd36, 16'hFFF0, 16'hFFFC, 16'hFFFC,
                               16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
   logic [15:0] exp_l1 [8] = '{16'd3, 16'd7, 16'd11, 16'd15,
                               16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};

   // 100 MHz clock.
   always #5 clk = ~clk;

   // Stub pair cores.
   assign core_ca_a = core_x0_a + core_x1_a;
   assign core_cd_a = core_x0_a - core_x1_a;
   assign core_ca_b = core_x0_b + core_x1_b;
   assign core_cd_b = core_x0_b - core_x1_b;

   dwt_haar_level_sched #(.N(8), .LEVELS(3), .W(16)) u_dut_l3 (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready_a), .core_x0(core_x0_a),
      .core_x1(core_x1_a), .core_cA(core_ca_a), .core_cD(core_cd_a),
      .core_valid(core_valid_a), .array_out(arr_a), .busy(busy_a),
      .done(done_a)
   );

   dwt_haar_level_sched #(.N(8), .LEVELS(1), .W(16)) u_dut_l1 (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready_b), .core_x0(core_x0_b),
      .core_x1(core_x1_b), .core_cA(core_ca_b), .core_cD(core_cd_b),
      .core_valid(core_valid_b), .array_out(arr_b), .busy(busy_b),
      .done(done_b)
   );

   // Cycle monitor: numbers rising edges and records, just after each edge,
   // when a block started (busy rose), when done was seen and what busy
   // looked like at and right after done.
   int cyc = 0;
   int start_cyc_a = 0, start_cyc_b = 0;
   int done_cyc_a = 0, done_cyc_b = 0;
   int done_count_a = 0, done_count_b = 0;
   logic busy_prev_a = 1'b0, busy_prev_b = 1'b0, done_prev_a = 1'b0;
   logic busy_at_done_a = 1'b0, busy_after_done_a = 1'b1;

   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (busy_a && !busy_prev_a) start_cyc_a = cyc;
      if (busy_b && !busy_prev_b) start_cyc_b = cyc;
      if (done_a) begin
         done_cyc_a     = cyc;
         done_count_a   = done_count_a + 1;
         busy_at_done_a = busy_a;
      end
      if (done_b) begin
         done_cyc_b   = cyc;
         done_count_b = done_count_b + 1;
      end
      if (done_prev_a) busy_after_done_a = busy_a;
      busy_prev_a = busy_a;
      busy_prev_b = busy_b;
      done_prev_a = done_a;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [15:0] elem(input logic [127:0] v, input int e);
      return v[e*16 +: 16];
   endfunction

   // Start a block (unless start is being held) and feed samples mul*1..mul*8,
   // optionally dropping in_valid for stall_len cycles after stall_after
   // samples. Acceptance is decided from in_ready sampled at the negedge.
   task automatic applyStimulus(input logic [15:0] mul, input int stall_after,
                                input int stall_len, input bit hold_start);
      int accepted;
      int stall_left;
      int guard;
      bit will_accept;
      accepted   = 0;
      stall_left = 0;
      guard      = 0;
      while (accepted < 8 && guard < 100) begin
         @(negedge clk);
         guard++;
         if (hold_start) start = 1'b1;
         else            start = !in_ready_a && (accepted == 0);
         if (stall_left > 0) begin
            in_valid = 1'b0;
            in_data  = 16'hDEAD;
            checkOutput("in_ready_stall", {31'd0, in_ready_a}, 32'd1);
            stall_left--;
         end else begin
            in_valid = 1'b1;
            in_data  = 16'(mul * 16'(accepted + 1));
         end
         will_accept = in_valid && in_ready_a;
         @(posedge clk);
         if (will_accept) begin
            accepted++;
            if (accepted == stall_after) stall_left = stall_len;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      if (!hold_start) start = 1'b0;
      checkOutput("load_count", accepted, 32'd8);
   endtask

   // Wait (bounded) until both instances are idle again; optionally pulse
   // start for one cycle at iteration pulse_at while they are computing.
   task automatic waitIdle(input int pulse_at);
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         start = (i == pulse_at);
         if (i > pulse_at && !busy_a && !busy_b) break;
      end
      start = 1'b0;
      checkOutput("idle_timeout", {30'd0, busy_a, busy_b}, 32'd0);
   endtask

   task automatic checkArrays(input string prefix, input logic [15:0] mul);
      for (int e = 0; e < 8; e++) begin
         checkOutput($sformatf("%s_l3_e%0d", prefix, e), {16'd0, elem(arr_a, e)},
                     {16'd0, 16'(exp_l3[e] * mul)});
         checkOutput($sformatf("%s_l1_e%0d", prefix, e), {16'd0, elem(arr_b, e)},
                     {16'd0, 16'(exp_l1[e] * mul)});
      end
   endtask

   task automatic checkResetOutputs(input string prefix);
      checkOutput({prefix, "_busy"},  {31'd0, busy_a}, 32'd0);
      checkOutput({prefix, "_done"},  {31'd0, done_a}, 32'd0);
      checkOutput({prefix, "_ready"}, {31'd0, in_ready_a}, 32'd0);
      checkOutput({prefix, "_cval"},  {31'd0, core_valid_a}, 32'd0);
      checkOutput({prefix, "_x0"},    {16'd0, core_x0_a}, 32'd0);
      checkOutput({prefix, "_x1"},    {16'd0, core_x1_a}, 32'd0);
      checkOutput({prefix, "_array"}, {31'd0, |arr_a}, 32'd0);
   endtask

   // Hard stop in case something wedges outside the bounded waits.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish, required finish before 200us");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main directed sequence.
   initial begin
      int base_a;
      int base_b;
      bit seen;

      rst_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      checkResetOutputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Samples 1..8 with in_valid held: L3 and L1 results and latency.
      base_a = done_count_a; base_b = done_count_b;
      applyStimulus(16'd1, 0, 0, 1'b0);
      waitIdle(-1);
      checkOutput("t1_lat_l3", done_cyc_a - start_cyc_a + 1, 32'd23);
      checkOutput("t1_lat_l1", done_cyc_b - start_cyc_b + 1, 32'd17);
      checkOutput("t1_dones_l3", done_count_a - base_a, 32'd1);
      checkOutput("t1_dones_l1", done_count_b - base_b, 32'd1);
      checkArrays("t1", 16'd1);

      // Three-cycle in_valid gap after sample 4: same result, 3 cycles later.
      applyStimulus(16'd1, 4, 3, 1'b0);
      waitIdle(-1);
      checkOutput("t3_lat_l3", done_cyc_a - start_cyc_a + 1, 32'd26);
      checkOutput("t3_lat_l1", done_cyc_b - start_cyc_b + 1, 32'd20);
      checkArrays("t3", 16'd1);

      // start pulsed while pairs are being processed must be ignored.
      base_a = done_count_a; base_b = done_count_b;
      applyStimulus(16'd1, 0, 0, 1'b0);
      waitIdle(3);
      checkOutput("t4_dones_l3", done_count_a - base_a, 32'd1);
      checkOutput("t4_dones_l1", done_count_b - base_b, 32'd1);
      checkOutput("t4_lat_l3", done_cyc_a - start_cyc_a + 1, 32'd23);
      checkOutput("t4_busy_at_done", {31'd0, busy_at_done_a}, 32'd1);
      checkOutput("t4_busy_after_done", {31'd0, busy_after_done_a}, 32'd0);
      repeat (3) @(negedge clk);
      checkOutput("t4_stays_idle", {31'd0, busy_a}, 32'd0);

      // Reset while the L3 instance is in level 2.
      base_a = done_count_a;
      applyStimulus(16'd1, 0, 0, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      checkOutput("t5_l2_x0", {16'd0, core_x0_a}, 32'd3);
      checkOutput("t5_l2_x1", {16'd0, core_x1_a}, 32'd7);
      rst_n = 1'b0;
      #1;
      checkResetOutputs("t5_rst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      checkOutput("t5_no_done", done_count_a - base_a, 32'd0);
      checkOutput("t5_idle", {31'd0, busy_a}, 32'd0);
      applyStimulus(16'd1, 0, 0, 1'b0);
      waitIdle(-1);
      checkOutput("t5_lat_l3", done_cyc_a - start_cyc_a + 1, 32'd23);
      checkArrays("t5", 16'd1);

      // Back-to-back blocks with start held high.
      base_a = done_count_a; base_b = done_count_b;
      applyStimulus(16'd1, 0, 0, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         seen = done_a;
      end
      checkOutput("t6_done_seen", {31'd0, seen}, 32'd1);
      @(negedge clk);
      checkOutput("t6_idle_busy", {31'd0, busy_a}, 32'd0);
      checkOutput("t6_hold_e0", {16'd0, elem(arr_a, 0)}, 32'd36);
      checkOutput("t6_hold_e1", {16'd0, elem(arr_a, 1)}, 32'hFFF0);
      @(negedge clk);
      checkOutput("t6_restart_busy", {31'd0, busy_a}, 32'd1);
      checkOutput("t6_restart_ready", {31'd0, in_ready_a}, 32'd1);
      checkOutput("t6_det_cleared", {16'd0, elem(arr_a, 1)}, 32'd0);
      checkOutput("t6_approx_kept", {16'd0, elem(arr_a, 0)}, 32'd36);
      applyStimulus(16'd2, 0, 0, 1'b1);
      start = 1'b0;
      waitIdle(-1);
      checkOutput("t6_dones_l3", done_count_a - base_a, 32'd2);
      checkOutput("t6_dones_l1", done_count_b - base_b, 32'd2);
      checkArrays("t6", 16'd2);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
